datamem_arbiter: RTL
====================

DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, word address width of the 128x32 data memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0 / req1  input  1  requester 0/1 transaction request, held high until its ack.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; stable while req high.
REQ-007 addr0 / addr1  input  ADDR_W  word address; stable while req high.
REQ-008 wdata0 / wdata1  input  DATA_W  write data; stable while req high.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse to requester 0/1.
REQ-010 rdata0 / rdata1  output  DATA_W  read result, valid in the ack cycle and held until the next read completion for that port.
REQ-011 mem_addr  output  ADDR_W  memory address, registered.
REQ-012 mem_wdata  output  DATA_W  memory write data, registered.
REQ-013 mem_write / mem_read  output  1  memory strobes, registered, mutually exclusive.
REQ-014 mem_rdata  input  DATA_W  memory read data, valid in the same cycle mem_read is high.

Function
REQ-015 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when any req high, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-016 In IDLE with one req high, that requester is granted; address, data and direction latched onto mem_* at the IDLE->ACCESS edge.
REQ-017 With req0 and req1 both high in IDLE, grant goes to the requester not served last (round-robin); last_grant updates at each grant.
REQ-018 In ACCESS exactly one of mem_write/mem_read is high for exactly one cycle; both low in IDLE and DONE.
REQ-019 Write commits to memory at the edge ending ACCESS; read data mem_rdata captured into the granted rdataN at the same edge.
REQ-020 In DONE, ackN of the granted requester high for exactly one cycle; other ack low; ack0 and ack1 never high together.
REQ-021 Latency: req sampled in IDLE at edge T -> ACCESS cycle T+1 -> ack cycle T+2; minimum 3 cycles per transaction, back-to-back throughput one transaction per 3 cycles.
REQ-022 Requester deasserts req or presents a new request at the edge ending its ack cycle; req high in IDLE is always a new request.
REQ-023 Once granted, a transaction completes even if req drops; req is ignored outside IDLE.
REQ-024 Non-granted requester's rdata holds its value; no ack is issued to it until its own grant.
REQ-025 A continuously requesting port cannot be granted twice in a row while the other port requests (no starvation; worst-case wait 6 cycles).
REQ-026 Address arithmetic none; mem_addr passes through unmodified, full range 0..2^ADDR_W-1 valid.

Reset
REQ-027 rst_n low: FSM to IDLE, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, ack0=ack1=0, rdata0=rdata1=0, last_grant=1 (requester 0 wins first tie), immediately and asynchronously.
REQ-028 Reset during ACCESS or DONE aborts the transaction: no ack issued, strobes drop without waiting for clk.
REQ-029 First grant possible at the first rising edge after rst_n deasserts.

Structure
REQ-030 Package datamem_pkg holds ADDR_W, DATA_W defaults and FSM state encoding constants.
REQ-031 One sub-module rr_arbiter2: inputs req0, req1, last_grant; outputs one-hot grant; purely combinational.
REQ-032 FSM, data latches and last_grant register reside in datamem_arbiter.

Verification
REQ-033 Single write: req0=1, we0=1, addr0=7'h05, wdata0=32'hDEADBEEF -> mem_write high one cycle with mem_addr=05, ack0 two cycles after sampling.
REQ-034 Readback: req1=1, we1=0, addr1=7'h05 with model memory -> rdata1=32'hDEADBEEF in ack1 cycle, rdata0 unchanged.
REQ-035 Tie after reset: req0=req1=1 held -> grants 0,1,0,1 alternating, ack every 3 cycles, never both acks high.
REQ-036 Wrap address: write 32'h12345678 to 7'h7F then read 7'h7F -> 32'h12345678; write to 7'h00 unaffected.
REQ-037 Reset mid-ACCESS: assert rst_n=0 during mem_write cycle -> strobes and ack 0 immediately, no ack after release, next request served by requester 0.
REQ-038 Req drop: req0 deasserted in ACCESS -> ack0 still issued in DONE, no second transaction started.

Source files
------------

// File: rtl/datamem_pkg.sv
// ---------------------------------------------------------------------------
// datamem_pkg: shared widths and FSM encoding for the data-memory arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package datamem_pkg;

  localparam int ADDR_W_DEFAULT = 7;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/datamem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter2: combinational two-way round-robin grant (one-hot). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
      // Tie goes to whichever requester was not served last.
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/datamem_arbiter.sv
// ---------------------------------------------------------------------------
// datamem_arbiter: two-requester round-robin access to a single-port data memory. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module datamem_arbiter
  import datamem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] grant;
  logic       last_grant;
  logic       sel;
  logic       start;
  logic       finish;

  rr_arbiter2 u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) begin
          state_nxt = ACCESS;
          start     = 1'b1;
        end
      end
      ACCESS: begin
        state_nxt = DONE;
        finish    = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // sel remembers the served port so a dropped req cannot cancel its ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      sel        <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (start) begin
        sel        <= grant[1];
        last_grant <= grant[1];
        mem_addr   <= grant[1] ? addr1  : addr0;
        mem_wdata  <= grant[1] ? wdata1 : wdata0;
        mem_write  <= grant[1] ? we1    : we0;
        mem_read   <= grant[1] ? ~we1   : ~we0;
      end else if (finish) begin
        mem_write <= 1'b0;
        mem_read  <= 1'b0;
        if (mem_read) begin
          if (sel) begin
            rdata1 <= mem_rdata;
          end else begin
            rdata0 <= mem_rdata;
          end
        end
        ack0 <= ~sel;
        ack1 <= sel;
      end
    end
  end

endmodule

`default_nettype wire
